xor_end_out: RTL and testbench

XOR_END_OUT -- requirements
Module: xor_end_out

---
 rtl/xor_end_out.sv | 143 ++++++++++++++
 tb/tb_xor_end_out.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xor_end_out.sv
// xor_end_out: output stage of a sponge permutation.
// Captures the 5x64 permutation state, optionally folds the key into words 3/4
// and the domain-separation bit into word 4, registers the result, and can
// stream {s3, s4} out as a two-beat tag over a valid/ready handshake.
// Build option: define XOR_END_TAG_CHECK_EN to compare the emitted tag against
// i_expected_tag; without it the match outputs are tied low.

package xor_end_out_pkg;
    typedef logic [4:0][63:0] t_state_array;
endpackage

// state  | meaning
// IDLE   | accepting captures, no tag in flight
// TAG_HI | presenting beat 0 (s3), waiting for i_tag_ready
// TAG_LO | presenting beat 1 (s4, last), waiting for i_tag_ready
module xor_end_out (
    input  logic                          clock,
    input  logic                          reset_n,
    input  xor_end_out_pkg::t_state_array i_state,
    input  logic                          i_state_valid,
    input  logic                          i_enable_xor_key,
    input  logic                          i_enable_xor_lsb,
    input  logic [127:0]                  i_key,
    input  logic                          i_tag_request,
    input  logic                          i_tag_ready,
    input  logic [127:0]                  i_expected_tag,
    output xor_end_out_pkg::t_state_array o_state,
    output logic                          o_state_valid,
    output logic [63:0]                   o_tag_data,
    output logic                          o_tag_valid,
    output logic                          o_tag_last,
    output logic                          o_busy,
    output logic                          o_tag_match,
    output logic                          o_tag_match_valid
);
    import xor_end_out_pkg::*;

    typedef enum logic [1:0] {IDLE, TAG_HI, TAG_LO} t_fsm;

    t_fsm         state_q;
    t_fsm         state_d;
    t_state_array s_q;
    t_state_array s_d;
    logic         state_valid_q;
    logic         capture;
    logic [127:0] key_mask;

    // Captures are only taken while no tag is in flight
    assign capture  = (state_q == IDLE) && i_state_valid;
    assign key_mask = i_enable_xor_key ? i_key : 128'd0;

    // Post-XOR value of the incoming state
    always_comb begin
        s_d              = i_state;
        {s_d[3], s_d[4]} = {i_state[3], i_state[4]} ^ key_mask;
        s_d[4][0]        = s_d[4][0] ^ i_enable_xor_lsb;
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (capture && i_tag_request) state_d = TAG_HI;
            TAG_HI:  if (i_tag_ready) state_d = TAG_LO;
            TAG_LO:  if (i_tag_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: tag beat presentation and busy flag
    always_comb begin
        o_tag_valid = 1'b0;
        o_tag_last  = 1'b0;
        o_tag_data  = 64'd0;
        o_busy      = 1'b0;
        case (state_q)
            TAG_HI: begin
                o_tag_valid = 1'b1;
                o_tag_data  = s_q[3];
                o_busy      = 1'b1;
            end
            TAG_LO: begin
                o_tag_valid = 1'b1;
                o_tag_last  = 1'b1;
                o_tag_data  = s_q[4];
                o_busy      = 1'b1;
            end
            default: ;
        endcase
    end

    // Registered state and its one-cycle update pulse
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            s_q           <= '0;
            state_valid_q <= 1'b0;
        end else begin
            state_valid_q <= capture;
            if (capture) begin
                s_q <= s_d;
            end
        end
    end

    assign o_state       = s_q;
    assign o_state_valid = state_valid_q;

`ifdef XOR_END_TAG_CHECK_EN
    logic match_q;
    logic match_valid_q;

    // Tag compare on the final beat's handshake; result held until next check
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            match_q       <= 1'b0;
            match_valid_q <= 1'b0;
        end else begin
            match_valid_q <= (state_q == TAG_LO) && i_tag_ready;
            if ((state_q == TAG_LO) && i_tag_ready) begin
                match_q <= ({s_q[3], s_q[4]} == i_expected_tag);
            end
        end
    end

    assign o_tag_match       = match_q;
    assign o_tag_match_valid = match_valid_q;
`else
    logic unused_expected_tag;
    assign unused_expected_tag = ^i_expected_tag;
    assign o_tag_match         = 1'b0;
    assign o_tag_match_valid   = 1'b0;
`endif

endmodule

// File: tb/tb_xor_end_out.sv
// Scoreboard bench for xor_end_out: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares whenever the DUT presents output.
module tb_xor_end_out;
    import xor_end_out_pkg::*;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
    } t_beat;

    logic         clock = 1'b0;
    logic         reset_n;
    t_state_array i_state;
    logic         i_state_valid;
    logic         i_enable_xor_key;
    logic         i_enable_xor_lsb;
    logic [127:0] i_key;
    logic         i_tag_request;
    logic         i_tag_ready;
    logic [127:0] i_expected_tag;
    t_state_array o_state;
    logic         o_state_valid;
    logic [63:0]  o_tag_data;
    logic         o_tag_valid;
    logic         o_tag_last;
    logic         o_busy;
    logic         o_tag_match;
    logic         o_tag_match_valid;

    t_state_array exp_state_q[$];
    t_beat        exp_tag_q[$];
    logic         exp_match_q[$];
    int           checks   = 0;
    int           failures = 0;
    bit           mon_en   = 1'b0;

    always #5 clock = ~clock;

    xor_end_out dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .i_state           (i_state),
        .i_state_valid     (i_state_valid),
        .i_enable_xor_key  (i_enable_xor_key),
        .i_enable_xor_lsb  (i_enable_xor_lsb),
        .i_key             (i_key),
        .i_tag_request     (i_tag_request),
        .i_tag_ready       (i_tag_ready),
        .i_expected_tag    (i_expected_tag),
        .o_state           (o_state),
        .o_state_valid     (o_state_valid),
        .o_tag_data        (o_tag_data),
        .o_tag_valid       (o_tag_valid),
        .o_tag_last        (o_tag_last),
        .o_busy            (o_busy),
        .o_tag_match       (o_tag_match),
        .o_tag_match_valid (o_tag_match_valid)
    );

    task automatic check(input string name, input logic [319:0] act, input logic [319:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic t_state_array mk(input logic [63:0] w0, w1, w2, w3, w4);
        t_state_array s;
        s[0] = w0; s[1] = w1; s[2] = w2; s[3] = w3; s[4] = w4;
        return s;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input t_state_array st, input logic [127:0] key,
                         input logic xk, input logic xl, input logic req);
        i_state          = st;
        i_key            = key;
        i_enable_xor_key = xk;
        i_enable_xor_lsb = xl;
        i_tag_request    = req;
        i_state_valid    = 1'b1;
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_state"},       o_state, 320'd0);
        check({tag, "_state_valid"}, o_state_valid, 320'd0);
        check({tag, "_tag_valid"},   o_tag_valid, 320'd0);
        check({tag, "_tag_last"},    o_tag_last, 320'd0);
        check({tag, "_tag_data"},    o_tag_data, 320'd0);
        check({tag, "_busy"},        o_busy, 320'd0);
        check({tag, "_match"},       o_tag_match, 320'd0);
        check({tag, "_match_valid"}, o_tag_match_valid, 320'd0);
    endtask

    // Monitor: compare DUT output against the scoreboard heads
    always @(negedge clock) begin
        if (mon_en) begin
            if (o_state_valid) begin
                if (exp_state_q.size() == 0) begin
                    check("state_unexpected_pulse", 320'd1, 320'd0);
                end else begin
                    check("state_value", o_state, exp_state_q.pop_front());
                end
            end
            if (o_tag_valid) begin
                if (exp_tag_q.size() == 0) begin
                    check("tag_unexpected_beat", 320'd1, 320'd0);
                end else begin
                    check("tag_data", o_tag_data, exp_tag_q[0].data);
                    check("tag_last", o_tag_last, exp_tag_q[0].last);
                    if (i_tag_ready) void'(exp_tag_q.pop_front());
                end
            end else begin
                check("tag_data_idle_zero", o_tag_data, 320'd0);
            end
`ifdef XOR_END_TAG_CHECK_EN
            if (o_tag_match_valid) begin
                if (exp_match_q.size() == 0) begin
                    check("match_unexpected_pulse", 320'd1, 320'd0);
                end else begin
                    check("tag_match", o_tag_match, exp_match_q.pop_front());
                end
            end
`else
            check("match_tied_low", {o_tag_match, o_tag_match_valid}, 320'd0);
`endif
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n          = 1'b0;
        i_state          = '0;
        i_state_valid    = 1'b0;
        i_enable_xor_key = 1'b0;
        i_enable_xor_lsb = 1'b0;
        i_key            = '0;
        i_tag_request    = 1'b0;
        i_tag_ready      = 1'b0;
        i_expected_tag   = '0;
        tick();
        tick();
        mon_en = 1'b1;
        check_idle_zero("reset");

        // Passthrough, accepted in the first cycle out of reset; key ignored
        reset_n = 1'b1;
        drive(mk(64'h1, 64'h2, 64'h3, 64'h4, 64'h5), {2{64'hDEAD_0000_BEEF_0001}}, 1'b0, 1'b0, 1'b0);
        exp_state_q.push_back(mk(64'h1, 64'h2, 64'h3, 64'h4, 64'h5));
        tick();
        i_state_valid = 1'b0;
        tick();
        tick();
        check("state_hold", o_state, mk(64'h1, 64'h2, 64'h3, 64'h4, 64'h5));

        // Finalization: key and lsb both applied
        drive(mk(64'h10, 64'h20, 64'h30, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF),
              {2{64'hAAAA_AAAA_AAAA_AAAA}}, 1'b1, 1'b1, 1'b0);
        exp_state_q.push_back(mk(64'h10, 64'h20, 64'h30, 64'h5555_5555_5555_5555, 64'h5555_5555_5555_5554));
        tick();
        i_state_valid = 1'b0;
        tick();

        // Key only
        drive(mk(64'h7, 64'h8, 64'h9, 64'h0123_4567_89AB_CDEF, 64'h0),
              {64'hFFFF_0000_FFFF_0000, 64'h1}, 1'b1, 1'b0, 1'b0);
        exp_state_q.push_back(mk(64'h7, 64'h8, 64'h9, 64'hFEDC_4567_7654_CDEF, 64'h1));
        tick();
        i_state_valid = 1'b0;
        tick();

        // LSB only; key present but disabled
        drive(mk(64'hC0, 64'hC1, 64'hC2, 64'hC3, 64'h8000_0000_0000_0001),
              {2{64'hFFFF_FFFF_FFFF_FFFF}}, 1'b0, 1'b1, 1'b0);
        exp_state_q.push_back(mk(64'hC0, 64'hC1, 64'hC2, 64'hC3, 64'h8000_0000_0000_0000));
        tick();
        i_state_valid = 1'b0;
        tick();

        // Back-to-back captures
        drive(mk(64'hA0, 64'hA1, 64'hA2, 64'hA3, 64'hA4), '0, 1'b0, 1'b0, 1'b0);
        exp_state_q.push_back(mk(64'hA0, 64'hA1, 64'hA2, 64'hA3, 64'hA4));
        tick();
        drive(mk(64'hB0, 64'hB1, 64'hB2, 64'hB3, 64'hB4), '0, 1'b0, 1'b1, 1'b0);
        exp_state_q.push_back(mk(64'hB0, 64'hB1, 64'hB2, 64'hB3, 64'hB5));
        tick();
        i_state_valid = 1'b0;
        tick();

        // Tag with 3 cycles of backpressure on the first beat
        i_tag_ready = 1'b0;
        drive(mk(64'h0, 64'h0, 64'h0, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222), '0, 1'b0, 1'b0, 1'b1);
        exp_state_q.push_back(mk(64'h0, 64'h0, 64'h0, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222));
        exp_tag_q.push_back('{data: 64'h1111_1111_1111_1111, last: 1'b0});
        exp_tag_q.push_back('{data: 64'h2222_2222_2222_2222, last: 1'b1});
        tick();
        i_state_valid = 1'b0;
        i_tag_request = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("bp_busy_hi", o_busy, 320'd1);
            check("bp_last_hi", o_tag_last, 320'd0);
            tick();
        end
        i_tag_ready = 1'b1;
        tick();
        check("bp_busy_lo", o_busy, 320'd1);
        check("bp_last_lo", o_tag_last, 320'd1);
        tick();
        check("bp_busy_done", o_busy, 320'd0);
        check("bp_valid_done", o_tag_valid, 320'd0);
        tick();
        tick();
        i_tag_ready = 1'b0;

        // Capture attempt during TAG_LO is dropped
        drive(mk(64'h0, 64'h0, 64'h0, 64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444), '0, 1'b0, 1'b0, 1'b1);
        exp_state_q.push_back(mk(64'h0, 64'h0, 64'h0, 64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444));
        exp_tag_q.push_back('{data: 64'h3333_3333_3333_3333, last: 1'b0});
        exp_tag_q.push_back('{data: 64'h4444_4444_4444_4444, last: 1'b1});
        tick();
        i_state_valid = 1'b0;
        i_tag_request = 1'b0;
        tick();
        i_tag_ready = 1'b1;
        tick();
        i_tag_ready = 1'b0;
        drive(mk(64'h9, 64'h9, 64'h9, 64'h9, 64'h9), '0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        i_state_valid = 1'b0;
        i_tag_ready   = 1'b1;
        tick();
        i_tag_ready = 1'b0;
        tick();
        check("drop_state_unchanged", o_state,
              mk(64'h0, 64'h0, 64'h0, 64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444));

        // Tag check: exact match, then a single flipped bit
        i_tag_ready    = 1'b1;
        i_expected_tag = {64'hDEAD_BEEF_0000_1111, 64'hBEEF_CAFE_2222_3333};
        drive(mk(64'h0, 64'h0, 64'h0, 64'hDEAD_BEEF_0000_1111, 64'hBEEF_CAFE_2222_3333), '0, 1'b0, 1'b0, 1'b1);
        exp_state_q.push_back(mk(64'h0, 64'h0, 64'h0, 64'hDEAD_BEEF_0000_1111, 64'hBEEF_CAFE_2222_3333));
        exp_tag_q.push_back('{data: 64'hDEAD_BEEF_0000_1111, last: 1'b0});
        exp_tag_q.push_back('{data: 64'hBEEF_CAFE_2222_3333, last: 1'b1});
`ifdef XOR_END_TAG_CHECK_EN
        exp_match_q.push_back(1'b1);
`endif
        tick();
        i_state_valid = 1'b0;
        i_tag_request = 1'b0;
        tick();
        tick();
        tick();
`ifdef XOR_END_TAG_CHECK_EN
        check("match_hold_1", o_tag_match, 320'd1);
`endif
        i_expected_tag = {64'hDEAD_BEEF_0000_1111, 64'hBEEF_CAFE_2222_3337};
        drive(mk(64'h0, 64'h0, 64'h0, 64'hDEAD_BEEF_0000_1111, 64'hBEEF_CAFE_2222_3333), '0, 1'b0, 1'b0, 1'b1);
        exp_state_q.push_back(mk(64'h0, 64'h0, 64'h0, 64'hDEAD_BEEF_0000_1111, 64'hBEEF_CAFE_2222_3333));
        exp_tag_q.push_back('{data: 64'hDEAD_BEEF_0000_1111, last: 1'b0});
        exp_tag_q.push_back('{data: 64'hBEEF_CAFE_2222_3333, last: 1'b1});
`ifdef XOR_END_TAG_CHECK_EN
        exp_match_q.push_back(1'b0);
`endif
        tick();
        i_state_valid = 1'b0;
        i_tag_request = 1'b0;
        tick();
        tick();
        tick();
        i_tag_ready = 1'b0;

        // Reset while in TAG_HI, with a simultaneous capture and ready
        drive(mk(64'h0, 64'h0, 64'h0, 64'h5555_5555_5555_5555, 64'h6666_6666_6666_6666), '0, 1'b0, 1'b0, 1'b1);
        exp_state_q.push_back(mk(64'h0, 64'h0, 64'h0, 64'h5555_5555_5555_5555, 64'h6666_6666_6666_6666));
        exp_tag_q.push_back('{data: 64'h5555_5555_5555_5555, last: 1'b0});
        tick();
        i_state_valid = 1'b0;
        i_tag_request = 1'b0;
        tick();
        check("pre_reset_busy", o_busy, 320'd1);
        reset_n = 1'b0;
        drive(mk(64'hE, 64'hE, 64'hE, 64'hE, 64'hE), '0, 1'b0, 1'b0, 1'b1);
        i_tag_ready = 1'b1;
        tick();
        exp_tag_q.delete();
        check_idle_zero("midtag_reset");
        reset_n     = 1'b1;
        i_tag_ready = 1'b0;
        drive(mk(64'h7, 64'h8, 64'h9, 64'hA, 64'hB), '0, 1'b0, 1'b0, 1'b0);
        exp_state_q.push_back(mk(64'h7, 64'h8, 64'h9, 64'hA, 64'hB));
        tick();
        i_state_valid = 1'b0;
        tick();
        tick();

        check("state_queue_drained", exp_state_q.size(), 320'd0);
        check("tag_queue_drained", exp_tag_q.size(), 320'd0);
        check("match_queue_drained", exp_match_q.size(), 320'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
